// File: rtl/kronos_types.sv
// Shared types and sizes for the Kronos issue controller.
// The FSM encoding lives here so other blocks can decode the state if needed.
package kronos_types;

  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {
    ISS_RUN   = 2'd0,
    ISS_DRAIN = 2'd1,
    ISS_ACK   = 2'd2
  } iss_state_e;

endpackage

// File: rtl/kronos_sb_counter.sv
// Per-register in-flight write counter for the issue scoreboard.
// Saturating up/down count with a synchronous clear and a retire-underflow flag.
module kronos_sb_counter #(
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic clk,
  input  logic rstz,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nz,
  output logic full,
  output logic err
);

  logic [CNT_W-1:0] cnt_q;

  assign nz   = (cnt_q != '0);
  assign full = (cnt_q == CNT_W'(MAX_PEND));

  // A retire with nothing in flight is a protocol error; a clear discards it silently.
  assign err = dec & ~clr & ~nz;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !dec && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec && !inc && nz) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/kronos_issue_ctrl.sv
// Scoreboard issue controller between decode and execute: holds decode on operand or
// write-slot conflicts against in-flight writes and sequences fence drains.
module kronos_issue_ctrl
  import kronos_types::*;
#(
  parameter int unsigned MAX_PEND = 3
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        dec_vld,
  output logic        dec_rdy,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        rs1_read,
  input  logic        rs2_read,
  input  logic        rd_write,
  output logic        iss_vld,
  input  logic        iss_rdy,
  input  logic        wb_vld,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  input  logic        drain_req,
  output logic        drain_ack,
  output logic [31:0] pending,
  output logic        wb_err
);

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

  localparam logic [1:0] ST_RUN   = ISS_RUN;
  localparam logic [1:0] ST_DRAIN = ISS_DRAIN;
  localparam logic [1:0] ST_ACK   = ISS_ACK;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic                req_block_q;
  logic                wb_err_q;
  logic [NUM_REGS-1:0] nz_vec;
  logic [NUM_REGS-1:0] full_vec;
  logic [NUM_REGS-1:1] err_vec;
  logic                hazard;
  logic                state_run;
  logic                fire;
  logic                wb_take;

  // x0 is hardwired: never pending, never full, never counted.
  assign nz_vec[0]   = 1'b0;
  assign full_vec[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    kronos_sb_counter #(
      .MAX_PEND (MAX_PEND),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rstz (rstz),
      .inc  (fire & rd_write & (rd == 5'(i))),
      .dec  (wb_take & (wb_rd == 5'(i))),
      .clr  (flush),
      .nz   (nz_vec[i]),
      .full (full_vec[i]),
      .err  (err_vec[i])
    );
  end

  // Hazard looks only at registered counts; a same-cycle writeback does not bypass.
  assign hazard = (rs1_read & nz_vec[rs1])
                | (rs2_read & nz_vec[rs2])
                | (rd_write & full_vec[rd]);

  assign state_run = (state_q == ST_RUN);
  assign iss_vld   = dec_vld & ~hazard & state_run & ~flush;
  assign dec_rdy   = iss_rdy & ~hazard & state_run & ~flush;
  assign fire      = iss_vld & iss_rdy;
  assign wb_take   = wb_vld & ~flush;

  assign pending   = nz_vec;
  assign drain_ack = (state_q == ST_ACK);
  assign wb_err    = wb_err_q;

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_req && !req_block_q && !flush) state_d = ST_DRAIN;
      ST_DRAIN: if (!(|nz_vec)) state_d = ST_ACK;
      ST_ACK:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // A drain_req still high after an acknowledge must drop for a cycle before it
  // can start another drain.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= ST_RUN;
      req_block_q <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ACK) begin
        req_block_q <= drain_req;
      end else if (!drain_req) begin
        req_block_q <= 1'b0;
      end
      wb_err_q <= wb_err_q | (|err_vec);
    end
  end

endmodule

// File: tb/tb_kronos_issue_ctrl.sv
// Directed bench for kronos_issue_ctrl: a cycle-by-cycle vector table plus hand
// sequences for flush during a drain and asynchronous reset mid-drain.
module tb_kronos_issue_ctrl;

  logic        clk;
  logic        rstz;
  logic        dec_vld;
  logic        dec_rdy;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        rs1_read;
  logic        rs2_read;
  logic        rd_write;
  logic        iss_vld;
  logic        iss_rdy;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        drain_req;
  logic        drain_ack;
  logic [31:0] pending;
  logic        wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  kronos_issue_ctrl #(.MAX_PEND(3)) dut (
    .clk       (clk),
    .rstz      (rstz),
    .dec_vld   (dec_vld),
    .dec_rdy   (dec_rdy),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .rs1_read  (rs1_read),
    .rs2_read  (rs2_read),
    .rd_write  (rd_write),
    .iss_vld   (iss_vld),
    .iss_rdy   (iss_rdy),
    .wb_vld    (wb_vld),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .drain_req (drain_req),
    .drain_ack (drain_ack),
    .pending   (pending),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dv;
    logic        ir;
    logic [4:0]  rs1;
    logic        r1;
    logic [4:0]  rs2;
    logic        r2;
    logic [4:0]  rd;
    logic        w;
    logic        wv;
    logic [4:0]  wrd;
    logic        fl;
    logic        dr;
    logic        e_iss;
    logic        e_rdy;
    logic [31:0] e_pend;
    logic        e_ack;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int dv, input int ir, input int s1, input int r1,
                              input int s2, input int r2, input int d, input int w,
                              input int wv, input int wrd, input int fl, input int dr,
                              input int e_iss, input int e_rdy, input logic [31:0] e_pend,
                              input int e_ack, input int e_err);
    vec_t v;
    v.dv = 1'(dv);  v.ir = 1'(ir);
    v.rs1 = 5'(s1); v.r1 = 1'(r1);
    v.rs2 = 5'(s2); v.r2 = 1'(r2);
    v.rd = 5'(d);   v.w = 1'(w);
    v.wv = 1'(wv);  v.wrd = 5'(wrd);
    v.fl = 1'(fl);  v.dr = 1'(dr);
    v.e_iss = 1'(e_iss); v.e_rdy = 1'(e_rdy); v.e_pend = e_pend;
    v.e_ack = 1'(e_ack); v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    dec_vld = v.dv;   iss_rdy = v.ir;
    rs1 = v.rs1;      rs1_read = v.r1;
    rs2 = v.rs2;      rs2_read = v.r2;
    rd = v.rd;        rd_write = v.w;
    wb_vld = v.wv;    wb_rd = v.wrd;
    flush = v.fl;     drain_req = v.dr;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // Short-hands for hand sequences: instruction write to d, and idle with drain/flush.
  function automatic vec_t wr(input int d, input int dr, input int fl);
    return mk(1, 1, 0, 0, 0, 0, d, 1, 0, 0, fl, dr, 0, 0, 32'h0, 0, 0);
  endfunction

  function automatic vec_t idle(input int dr, input int fl);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fl, dr, 0, 0, 32'h0, 0, 0);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    //                dv ir s1 r1 s2 r2 rd w  wv wrd fl dr | iss rdy pend      ack err
    // load-use hold on x5, released one cycle after its writeback
    tbl.push_back(mk(1, 1, 2, 1, 0, 0, 5, 1, 0, 0, 0, 0,   1, 1, 32'h0,     0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0,   0, 0, 32'h20,    0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 1, 1, 6, 1, 1, 5, 0, 0,   0, 0, 32'h20,    0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0,   1, 1, 32'h0,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0,   0, 0, 32'h40,    0, 0));
    // write-slot saturation on x7
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, (i == 0) ? 32'h0 : 32'h80, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 0, 32'h80,    0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0,   0, 0, 32'h80,    0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   1, 1, 32'h80,    0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 0, 32'h80,    0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h80, 0, 0));
    // same-cycle fire and writeback on x9 leaves the count at 1
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   1, 1, 32'h0,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0,   1, 1, 32'h200,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0,   0, 0, 32'h200,   0, 0));
    // x0 is never counted and never stalls
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 32'h0,     0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0));
    // drain with x3=2, x4=1 outstanding
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   1, 1, 32'h0,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   1, 1, 32'h8,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1,   1, 1, 32'h8,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1,   0, 0, 32'h18,    0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 1, 3, 0, 1,   0, 0, 32'h18,    0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 1, 3, 0, 1,   0, 0, 32'h18,    0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 1, 4, 0, 1,   0, 0, 32'h10,    0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1,   0, 0, 32'h0,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1,   0, 0, 32'h0,     1, 0));
    // held drain_req after the ack must not start a new drain
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1,   1, 1, 32'h0,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 32'h100,   0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0,  1, 1, 32'h100,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0,   0, 0, 32'h900,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0,  0, 0, 32'h800,   0, 0));
    // flush kills x10 writes and swallows writebacks; a later stray wb is sticky
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0,  1, 1, 32'h0,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0,  1, 1, 32'h400,   0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 12, 1, 1, 10, 1, 0, 0, 0, 32'h400,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 0,  0, 0, 32'h0,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0,  0, 0, 32'h0,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,     0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,     0, 1));

    rstz = 1'b0;
    drive(idle(0, 0));
    repeat (2) @(negedge clk);
    check("reset_pending", pending, 32'h0);
    check("reset_ack", 32'(drain_ack), 32'h0);
    check("reset_err", 32'(wb_err), 32'h0);
    rstz = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("r%0d_iss_vld", i), 32'(iss_vld), 32'(tbl[i].e_iss));
      check($sformatf("r%0d_dec_rdy", i), 32'(dec_rdy), 32'(tbl[i].e_rdy));
      check($sformatf("r%0d_pending", i), pending, tbl[i].e_pend);
      check($sformatf("r%0d_drain_ack", i), 32'(drain_ack), 32'(tbl[i].e_ack));
      check($sformatf("r%0d_wb_err", i), 32'(wb_err), 32'(tbl[i].e_err));
    end

    // Flush while draining: counters clear, ack follows one cycle later.
    @(negedge clk); drive(wr(13, 0, 0)); #1;
    check("fd_issue", 32'(iss_vld), 32'h1);
    @(negedge clk); drive(idle(1, 0)); #1;
    check("fd_pending", pending, 32'h2000);
    @(negedge clk); drive(wr(16, 1, 1)); #1;
    check("fd_flush_no_issue", 32'(iss_vld), 32'h0);
    check("fd_flush_no_ack", 32'(drain_ack), 32'h0);
    @(negedge clk); drive(idle(1, 0)); #1;
    check("fd_cleared", pending, 32'h0);
    check("fd_ack_not_yet", 32'(drain_ack), 32'h0);
    @(negedge clk); drive(idle(0, 0)); #1;
    check("fd_ack", 32'(drain_ack), 32'h1);
    @(negedge clk); drive(idle(0, 0)); #1;
    check("fd_ack_one_cycle", 32'(drain_ack), 32'h0);
    check("fd_err_kept", 32'(wb_err), 32'h1);

    // Asynchronous reset in the middle of a drain.
    @(negedge clk); drive(wr(14, 0, 0)); #1;
    check("rd_issue", 32'(iss_vld), 32'h1);
    @(negedge clk); drive(idle(1, 0));
    @(negedge clk); drive(wr(15, 1, 0)); #1;
    check("rd_draining", 32'(iss_vld), 32'h0);
    check("rd_pending", pending, 32'h4000);
    #1 rstz = 1'b0;
    #1;
    check("rd_rst_pending", pending, 32'h0);
    check("rd_rst_err", 32'(wb_err), 32'h0);
    check("rd_rst_ack", 32'(drain_ack), 32'h0);
    drive(idle(0, 0));
    #1;
    check("rd_rst_iss", 32'(iss_vld), 32'h0);
    check("rd_rst_rdy", 32'(dec_rdy), 32'h0);
    @(negedge clk); rstz = 1'b1; drive(wr(15, 0, 0)); #1;
    check("rd_run_iss", 32'(iss_vld), 32'h1);
    check("rd_run_ack", 32'(drain_ack), 32'h0);
    @(negedge clk); drive(idle(0, 0)); #1;
    check("rd_after_pending", pending, 32'h8000);
    check("rd_after_ack", 32'(drain_ack), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
